muntjac_hpm_counters: RTL and testbench

MUNTJAC_HPM_COUNTERS -- requirements
Module: muntjac_hpm_counters

---
 rtl/muntjac_pkg.sv | 47 ++++
 rtl/muntjac_hpm_counter.sv | 31 +++
 rtl/muntjac_hpm_counters.sv | 136 +++++++++++++
 tb/tb_muntjac_hpm_counters.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muntjac_pkg.sv
// Shared CSR encodings and privilege levels for the Muntjac core.
// Also holds the CSR read-modify-write helper used by the counter block.
package muntjac_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MHPMEVENT3    = 12'h323,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MHPMCOUNTER3  = 12'hB03,
    CSR_CYCLE         = 12'hC00,
    CSR_INSTRET       = 12'hC02,
    CSR_HPMCOUNTER3   = 12'hC03
  } csr_num_e;

  localparam int unsigned CSR_HPM_MAX_COUNTERS   = 29;
  localparam int unsigned CSR_MCOUNTINHIBIT_CY   = 0;
  localparam int unsigned CSR_MCOUNTINHIBIT_IR   = 2;
  localparam int unsigned CSR_MCOUNTINHIBIT_HPM3 = 3;

  function automatic logic [63:0] csr_apply(csr_op_e op, logic [63:0] old, logic [63:0] wdata);
    logic [63:0] res;
    res = old;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = old | wdata;
      CSR_OP_CLEAR: res = old & ~wdata;
      default:      res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muntjac_hpm_counter.sv
// One wrapping event counter; a write beats a same-cycle increment and never flags overflow.
// New value and the one-cycle overflow pulse appear the cycle after inc/we.
module muntjac_hpm_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             we,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] value,
  output logic             overflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      overflow <= 1'b0;
    end else if (we) begin
      value    <= wdata;
      overflow <= 1'b0;
    end else if (inc && !inhibit) begin
      value    <= value + Width'(1);
      overflow <= &value;
    end else begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/muntjac_hpm_counters.sv
// Machine/user counter CSRs: mcycle, minstret, mhpmcounterN, mhpmeventN and mcountinhibit.
// Reads are combinational with pre-update data; writes and increments land on the next edge.
module muntjac_hpm_counters
  import muntjac_pkg::*;
#(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_valid_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic [1:0]  priv_lvl_i,
  input  logic [31:0] mcounteren_i,
  input  logic [31:0] scounteren_i,
  input  logic [NumEvents-1:0] events_i,
  input  logic        instret_i,
  output logic        csr_hit_o,
  output logic        csr_illegal_o,
  output logic [63:0] csr_rdata_o,
  output logic [31:0] overflow_o
);

  localparam int unsigned NC = (NumCounters > 0) ? NumCounters : 1;
  localparam logic [11:0] AddrMCnt = CSR_MCYCLE;
  localparam logic [11:0] AddrUCnt = CSR_CYCLE;
  localparam logic [11:0] AddrMCfg = CSR_MCOUNTINHIBIT;
  localparam logic [31:0] InhibitMask =
      32'h5 | (((32'd1 << NumCounters) - 32'd1) << CSR_MCOUNTINHIBIT_HPM3);

  csr_op_e   op;
  priv_lvl_e priv;
  logic [4:0]  idx;
  logic        space_b, space_c, space_e, illegal, wr_en;
  logic [63:0] old_val, new_val;
  logic [7:0]  evt_wdata;
  logic [31:0] inhibit;
  logic [7:0]  evt_sel [NC];
  logic [CounterWidth-1:0] hpm_val [NC];
  logic [NC-1:0] hpm_inc, hpm_ovf;
  logic [63:0] mcycle, minstret;
  logic        cy_ovf, ir_ovf;

  assign op   = csr_op_e'(csr_op_i);
  assign priv = priv_lvl_e'(priv_lvl_i);
  assign idx  = csr_addr_i[4:0];

  // Index 1 in the counter spaces is TIME, which lives elsewhere.
  assign space_b   = (csr_addr_i[11:5] == AddrMCnt[11:5]) && (idx != 5'd1);
  assign space_c   = (csr_addr_i[11:5] == AddrUCnt[11:5]) && (idx != 5'd1);
  assign space_e   = (csr_addr_i[11:5] == AddrMCfg[11:5]) && (idx == 5'd0 || idx >= 5'd3);
  assign csr_hit_o = space_b | space_c | space_e;

  always_comb begin
    illegal = 1'b0;
    if ((space_b || space_e) && priv != PRIV_LVL_M) illegal = 1'b1;
    if (space_c) begin
      if (op != CSR_OP_READ) illegal = 1'b1;
      if (priv == PRIV_LVL_S && !mcounteren_i[idx]) illegal = 1'b1;
      if (priv == PRIV_LVL_U && !(mcounteren_i[idx] & scounteren_i[idx])) illegal = 1'b1;
    end
  end

  assign csr_illegal_o = csr_valid_i & csr_hit_o & illegal;
  assign wr_en = csr_valid_i & csr_hit_o & ~illegal & (op != CSR_OP_READ) & ~rst_i;

  always_comb begin
    old_val = '0;
    if (space_b || space_c) begin
      if (idx == 5'd0) old_val = mcycle;
      if (idx == 5'd2) old_val = minstret;
      for (int k = 0; k < NumCounters; k++)
        if (idx == 5'(k + 3)) old_val = 64'(hpm_val[k]);
    end else if (space_e) begin
      if (idx == 5'd0) old_val = 64'(inhibit);
      for (int k = 0; k < NumCounters; k++)
        if (idx == 5'(k + 3)) old_val = 64'(evt_sel[k]);
    end
  end

  assign new_val     = csr_apply(op, old_val, csr_wdata_i);
  assign evt_wdata   = (new_val > 64'(NumEvents)) ? 8'd0 : new_val[7:0];
  assign csr_rdata_o = (csr_valid_i && csr_hit_o && !illegal && !rst_i) ? old_val : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit <= '0;
      for (int k = 0; k < NC; k++) evt_sel[k] <= '0;
    end else if (wr_en && space_e) begin
      if (idx == 5'd0) inhibit <= new_val[31:0] & InhibitMask;
      for (int k = 0; k < NumCounters; k++)
        if (idx == 5'(k + 3)) evt_sel[k] <= evt_wdata;
    end
  end

  always_comb begin
    hpm_inc = '0;
    for (int k = 0; k < NumCounters; k++)
      for (int e = 1; e <= NumEvents; e++)
        if (evt_sel[k] == 8'(e) && events_i[e-1]) hpm_inc[k] = 1'b1;
  end

  muntjac_hpm_counter #(.Width(64)) u_mcycle (
    .clk(clk_i), .rst(rst_i), .inc(1'b1), .inhibit(inhibit[CSR_MCOUNTINHIBIT_CY]),
    .we(wr_en && space_b && idx == 5'd0), .wdata(new_val), .value(mcycle), .overflow(cy_ovf)
  );

  muntjac_hpm_counter #(.Width(64)) u_minstret (
    .clk(clk_i), .rst(rst_i), .inc(instret_i), .inhibit(inhibit[CSR_MCOUNTINHIBIT_IR]),
    .we(wr_en && space_b && idx == 5'd2), .wdata(new_val), .value(minstret), .overflow(ir_ovf)
  );

  for (genvar k = 0; k < NC; k++) begin : g_hpm
    if (k < NumCounters) begin : g_on
      muntjac_hpm_counter #(.Width(CounterWidth)) u_cnt (
        .clk(clk_i), .rst(rst_i), .inc(hpm_inc[k]), .inhibit(inhibit[k+3]),
        .we(wr_en && space_b && idx == 5'(k + 3)), .wdata(new_val[CounterWidth-1:0]),
        .value(hpm_val[k]), .overflow(hpm_ovf[k])
      );
    end else begin : g_off
      assign hpm_val[k] = '0;
      assign hpm_ovf[k] = 1'b0;
    end
  end

  always_comb begin
    overflow_o = '0;
    overflow_o[CSR_MCOUNTINHIBIT_CY] = cy_ovf;
    overflow_o[CSR_MCOUNTINHIBIT_IR] = ir_ovf;
    for (int k = 0; k < NumCounters; k++) overflow_o[k+3] = hpm_ovf[k];
  end

endmodule

// File: tb/tb_muntjac_hpm_counters.sv
// Directed bench for muntjac_hpm_counters (8-bit hpm counters, 4 counters, 16 events).
module tb_muntjac_hpm_counters;

  localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_SET = 2'd2, OP_CLR = 2'd3;
  localparam logic [1:0] PU = 2'd0, PS = 2'd1, PM = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_valid = 1'b0;
  logic [1:0]  csr_op = OP_RD;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic [1:0]  priv = PM;
  logic [31:0] mcounteren = '0, scounteren = '0;
  logic [15:0] events = '0;
  logic        instret = 1'b0;
  logic        csr_hit, csr_illegal;
  logic [63:0] csr_rdata;
  logic [31:0] overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] rd, cyc, frozen;
  logic        ill, hit, acc_ill;

  muntjac_hpm_counters #(.NumCounters(4), .CounterWidth(8), .NumEvents(16)) dut (
    .clk_i(clk), .rst_i(rst), .csr_valid_i(csr_valid), .csr_op_i(csr_op),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .priv_lvl_i(priv),
    .mcounteren_i(mcounteren), .scounteren_i(scounteren), .events_i(events),
    .instret_i(instret), .csr_hit_o(csr_hit), .csr_illegal_o(csr_illegal),
    .csr_rdata_o(csr_rdata), .overflow_o(overflow)
  );

  always #10 clk = ~clk;

  // Free-running cycle count since reset release, used as the expected mcycle.
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [11:0] a, input logic [1:0] p);
    csr_valid = 1'b1; csr_op = OP_RD; csr_addr = a; priv = p;
    #1;
    rd = csr_rdata; ill = csr_illegal; hit = csr_hit;
    csr_valid = 1'b0;
  endtask

  task automatic acc(input logic [1:0] o, input logic [11:0] a, input logic [63:0] wd,
                     input logic [1:0] p);
    @(negedge clk);
    csr_valid = 1'b1; csr_op = o; csr_addr = a; csr_wdata = wd; priv = p;
    #1 acc_ill = csr_illegal;
    @(negedge clk);
    csr_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    peek(12'hB00, PM); check("rdata_in_reset", rd, 64'h0);
    rst = 1'b0;
    peek(12'hB00, PM); check("mcycle_reset", rd, 64'h0);
    peek(12'hB02, PM); check("minstret_reset", rd, 64'h0);
    peek(12'h320, PM); check("inhibit_reset", rd, 64'h0);
    peek(12'h323, PM); check("event3_reset", rd, 64'h0);
    check("overflow_reset", 64'(overflow), 64'h0);

    repeat (5) @(negedge clk);
    peek(12'hB00, PM); check("mcycle_count5", rd, 64'd5);

    acc(OP_WR, 12'h323, 64'hFF, PM); check("evt_write_legal", 64'(acc_ill), 64'h0);
    peek(12'h323, PM); check("evt_warl_ff", rd, 64'h0);
    acc(OP_WR, 12'h323, 64'h5, PM);
    peek(12'h323, PM); check("evt_write5", rd, 64'h5);
    acc(OP_CLR, 12'h323, 64'h4, PM);
    peek(12'h323, PM); check("evt_clear", rd, 64'h1);
    acc(OP_SET, 12'h323, 64'h2, PM);
    peek(12'h323, PM); check("evt_set", rd, 64'h3);
    acc(OP_WR, 12'h323, 64'h1, PM);
    peek(12'h323, PM); check("evt_write1", rd, 64'h1);

    @(negedge clk);
    csr_valid = 1'b1; csr_op = OP_WR; csr_addr = 12'hB02; csr_wdata = 64'h10; priv = PM;
    instret = 1'b1;
    @(negedge clk);
    csr_valid = 1'b0; instret = 1'b0;
    peek(12'hB02, PM); check("minstret_write_wins", rd, 64'h10);
    instret = 1'b1;
    repeat (3) @(negedge clk);
    instret = 1'b0;
    peek(12'hB02, PM); check("minstret_count", rd, 64'h13);

    acc(OP_WR, 12'hC02, 64'h55, PM); check("user_write_illegal", 64'(acc_ill), 64'h1);
    peek(12'hB02, PM); check("illegal_no_effect", rd, 64'h13);
    peek(12'hB00, PS); check("mspace_s_illegal", 64'(ill), 64'h1);
    check("mspace_s_rdata", rd, 64'h0);

    events = 16'h0001;
    repeat (255) @(negedge clk);
    peek(12'hB03, PM); check("hpm3_at_ff", rd, 64'hFF);
    check("no_ovf_before_wrap", 64'(overflow), 64'h0);
    @(negedge clk);
    peek(12'hB03, PM); check("hpm3_wrapped", rd, 64'h0);
    check("ovf3_pulse", 64'(overflow), 64'h8);
    peek(12'hB04, PM); check("hpm4_event0", rd, 64'h0);
    events = 16'h0000;
    @(negedge clk);
    check("ovf3_one_cycle", 64'(overflow), 64'h0);

    events = 16'h0001;
    acc(OP_WR, 12'hB03, 64'hFF, PM);
    peek(12'hB03, PM); check("hpm3_write_wins", rd, 64'hFF);
    check("write_no_ovf", 64'(overflow), 64'h0);
    @(negedge clk);
    peek(12'hB03, PM); check("hpm3_wrap2", rd, 64'h0);
    check("ovf3_pulse2", 64'(overflow), 64'h8);
    events = 16'h0000;

    @(negedge clk);
    mcounteren = 32'h1; scounteren = 32'h0;
    peek(12'hC00, PU); check("cycle_u_illegal", 64'(ill), 64'h1);
    check("cycle_u_rdata", rd, 64'h0);

    acc(OP_SET, 12'h320, 64'h1, PM);
    frozen = cyc;
    repeat (10) @(negedge clk);
    peek(12'hB00, PM); check("mcycle_frozen", rd, frozen);
    peek(12'hC00, PS); check("cycle_s_legal", 64'(ill), 64'h0);
    check("cycle_s_rdata", rd, frozen);
    peek(12'h320, PM); check("inhibit_readback", rd, 64'h1);

    @(negedge clk);
    peek(12'hB1F, PM); check("b1f_hit", 64'(hit), 64'h1);
    check("b1f_legal", 64'(ill), 64'h0);
    check("b1f_zero", rd, 64'h0);
    peek(12'hB01, PM); check("b01_nohit", 64'(hit), 64'h0);
    peek(12'hC01, PM); check("c01_nohit", 64'(hit), 64'h0);
    peek(12'h321, PM); check("321_nohit", 64'(hit), 64'h0);
    peek(12'hB80, PM); check("b80_nohit", 64'(hit), 64'h0);

    acc(OP_WR, 12'h320, 64'hFFFF_FFFF_FFFF_FFFF, PM);
    peek(12'h320, PM); check("inhibit_mask", rd, 64'h7D);
    acc(OP_WR, 12'hB04, 64'h1AB, PM);
    peek(12'hB04, PM); check("hpm4_truncate", rd, 64'hAB);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    peek(12'hB04, PM); check("hpm4_after_reset", rd, 64'h0);
    peek(12'h320, PM); check("inhibit_after_reset", rd, 64'h0);
    peek(12'h323, PM); check("event3_after_reset", rd, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
